// File: rtl/debug_uart_controller_pkg.sv
// Shared constants for the UART debug controller: command bytes, TX codes and
// the sequencer state encoding.
package debug_uart_controller_pkg;

    localparam logic [7:0] CMD_RUN  = 8'h63;
    localparam logic [7:0] CMD_STEP = 8'h73;
    localparam logic [7:0] CMD_RST  = 8'h72;
    localparam logic [7:0] CMD_DUMP = 8'h64;

    localparam logic [7:0] TX_TERM  = 8'h0A;
    localparam logic [7:0] TX_NAK   = 8'h3F;

    localparam int         ST_W     = 4;
    localparam logic [3:0] ST_IDLE   = 4'd0;
    localparam logic [3:0] ST_FETCH  = 4'd1;
    localparam logic [3:0] ST_DECODE = 4'd2;
    localparam logic [3:0] ST_RUN    = 4'd3;
    localparam logic [3:0] ST_STEP   = 4'd4;
    localparam logic [3:0] ST_PRST   = 4'd5;
    localparam logic [3:0] ST_LOAD   = 4'd6;
    localparam logic [3:0] ST_SEND   = 4'd7;
    localparam logic [3:0] ST_END    = 4'd8;
    localparam logic [3:0] ST_ERR    = 4'd9;

    function automatic logic is_tx_state(input logic [3:0] state);
        return (state == ST_SEND) || (state == ST_END) || (state == ST_ERR);
    endfunction

endpackage

// File: rtl/debug_uart_controller.sv
// Command sequencer between the UART byte FIFOs and the pipeline under debug:
// runs/steps/resets the pipeline and streams the debug word bank out as bytes.
module debug_uart_controller
    import debug_uart_controller_pkg::*;
#(
    parameter int DUMP_WORDS = 8,
    parameter int IDX_W      = $clog2(DUMP_WORDS)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_rx_empty,
    input  logic [7:0]       i_rx_data,
    output logic             o_rx_read_next,
    input  logic             i_tx_full,
    output logic             o_tx_write_flag,
    output logic [7:0]       o_tx_data,
    input  logic             i_halted,
    output logic             o_pipe_enable,
    output logic             o_pipe_reset,
    output logic [IDX_W-1:0] o_dump_index,
    input  logic [31:0]      i_dump_word
);

    logic [ST_W-1:0]  r_state;
    logic [ST_W-1:0]  w_next_state;
    logic [7:0]       r_cmd;
    logic [31:0]      r_shift;
    logic [1:0]       r_bytecnt;
    logic [IDX_W-1:0] r_dump_index;
    logic             r_load_wait;
    logic             w_last_word;
    logic             w_last_byte;

    assign w_last_word  = (r_dump_index == IDX_W'(DUMP_WORDS - 1));
    assign w_last_byte  = (r_bytecnt == 2'd3);
    assign o_dump_index = r_dump_index;

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:   w_next_state = i_rx_empty ? ST_IDLE : ST_FETCH;
            ST_FETCH:  w_next_state = ST_DECODE;
            ST_DECODE: begin
                case (r_cmd)
                    CMD_RUN:  w_next_state = ST_RUN;
                    CMD_STEP: w_next_state = ST_STEP;
                    CMD_RST:  w_next_state = ST_PRST;
                    CMD_DUMP: w_next_state = ST_LOAD;
                    default:  w_next_state = ST_ERR;
                endcase
            end
            ST_RUN:    w_next_state = i_halted ? ST_LOAD : ST_RUN;
            ST_STEP:   w_next_state = ST_LOAD;
            ST_PRST:   w_next_state = ST_IDLE;
            // The word mux is registered, so the captured word lags the index by a cycle
            ST_LOAD:   w_next_state = r_load_wait ? ST_SEND : ST_LOAD;
            ST_SEND: begin
                if (!i_tx_full && w_last_byte) begin
                    w_next_state = w_last_word ? ST_END : ST_LOAD;
                end else begin
                    w_next_state = ST_SEND;
                end
            end
            ST_END:    w_next_state = i_tx_full ? ST_END : ST_IDLE;
            ST_ERR:    w_next_state = i_tx_full ? ST_ERR : ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        o_rx_read_next  = (r_state == ST_FETCH);
        o_tx_write_flag = is_tx_state(r_state) && !i_tx_full;
        o_pipe_enable   = (r_state == ST_STEP) || ((r_state == ST_RUN) && !i_halted);
        o_pipe_reset    = (r_state == ST_PRST);
        case (r_state)
            ST_SEND: o_tx_data = r_shift[31:24];
            ST_END:  o_tx_data = TX_TERM;
            ST_ERR:  o_tx_data = TX_NAK;
            default: o_tx_data = 8'h00;
        endcase
    end

    // Command, shift register, byte count and dump index
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cmd        <= 8'h00;
            r_shift      <= 32'h0000_0000;
            r_bytecnt    <= 2'd0;
            r_dump_index <= '0;
            r_load_wait  <= 1'b0;
        end else begin
            case (r_state)
                ST_FETCH: r_cmd <= i_rx_data;
                ST_DECODE, ST_RUN, ST_STEP: begin
                    r_dump_index <= '0;
                    r_load_wait  <= 1'b0;
                end
                ST_LOAD: begin
                    if (r_load_wait) begin
                        r_shift     <= i_dump_word;
                        r_bytecnt   <= 2'd0;
                        r_load_wait <= 1'b0;
                    end else begin
                        r_load_wait <= 1'b1;
                    end
                end
                ST_SEND: begin
                    if (!i_tx_full) begin
                        r_shift   <= {r_shift[23:0], 8'h00};
                        r_bytecnt <= r_bytecnt + 2'd1;
                        if (w_last_byte && !w_last_word) begin
                            r_dump_index <= r_dump_index + IDX_W'(1);
                        end
                    end
                end
                ST_END: begin
                    if (!i_tx_full) begin
                        r_dump_index <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_debug_uart_controller.sv
// Randomized scoreboard bench for debug_uart_controller with FIFO, pipeline
// and word-mux models.
module tb_debug_uart_controller;

    localparam int NW = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        rx_empty;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_read_next;
    logic        tx_full = 1'b0;
    logic        tx_write_flag;
    logic [7:0]  tx_data;
    logic        halted;
    logic        pipe_enable;
    logic        pipe_reset;
    logic [1:0]  dump_index;
    logic [31:0] dump_word = 32'h0;

    int checks = 0;
    int failures = 0;
    int act_pops = 0, act_resets = 0, act_en = 0, act_writes = 0;
    int exp_pops = 0, exp_resets = 0, exp_en = 0;
    int pc_m = 0;
    logic [7:0] tx_exp[$];

    logic [7:0]  rx_mem[0:63];
    logic [5:0]  rx_wr = 6'd0;
    logic [5:0]  rx_rd = 6'd0;
    logic [7:0]  pc = 8'd0;
    logic [7:0]  prog_len = 8'd0;
    logic [31:0] dmem[0:NW-1];
    logic        full_rand_en = 1'b0;
    logic        burst_arm = 1'b0;
    int          burst_base = 0;

    debug_uart_controller #(.DUMP_WORDS(NW), .IDX_W(2)) dut (
        .clock(clock), .reset(reset),
        .i_rx_empty(rx_empty), .i_rx_data(rx_data), .o_rx_read_next(rx_read_next),
        .i_tx_full(tx_full), .o_tx_write_flag(tx_write_flag), .o_tx_data(tx_data),
        .i_halted(halted), .o_pipe_enable(pipe_enable), .o_pipe_reset(pipe_reset),
        .o_dump_index(dump_index), .i_dump_word(dump_word)
    );

    always #5 clock = ~clock;

    // RX FIFO with registered head byte
    assign rx_empty = (rx_wr == rx_rd);
    always @(posedge clock) begin
        if (rx_read_next && !rx_empty) rx_rd <= rx_rd + 6'd1;
        rx_data <= rx_mem[rx_rd];
    end

    // Pipeline: halts once it has executed prog_len instructions
    assign halted = (pc >= prog_len);
    always @(posedge clock) begin
        if (pipe_reset) pc <= 8'd0;
        else if (pipe_enable) pc <= pc + 8'd1;
    end

    // Registered debug word mux
    always @(posedge clock) dump_word <= dmem[dump_index];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic push_rx(input logic [7:0] b);
        rx_mem[rx_wr] = b;
        rx_wr = rx_wr + 6'd1;
    endtask

    task automatic model_dump();
        for (int w = 0; w < NW; w++)
            for (int b = 3; b >= 0; b--)
                tx_exp.push_back(dmem[w][8*b +: 8]);
        tx_exp.push_back(8'h0A);
    endtask

    // Command semantics at byte level
    task automatic model_cmd(input logic [7:0] c);
        exp_pops++;
        case (c)
            8'h63: begin
                if (pc_m < int'(prog_len)) begin
                    exp_en += int'(prog_len) - pc_m;
                    pc_m = int'(prog_len);
                end
                model_dump();
            end
            8'h73: begin exp_en++; pc_m++; model_dump(); end
            8'h72: begin exp_resets++; pc_m = 0; end
            8'h64: model_dump();
            default: tx_exp.push_back(8'h3F);
        endcase
    endtask

    task automatic wait_done(output logic timed_out);
        int t = 0;
        while (!(rx_empty && tx_exp.size() == 0) && t < 3000) begin
            @(posedge clock); #1;
            t++;
        end
        timed_out = (t >= 3000);
        if (timed_out) begin
            failures++;
            $display("FAIL timeout actual=%0d_pending expected=0", tx_exp.size());
        end
        repeat (6) begin @(posedge clock); #1; end
    endtask

    task automatic run_batch(input logic [7:0] c0, input logic [7:0] c1, input int n, output logic timed_out);
        push_rx(c0); model_cmd(c0);
        if (n > 1) begin push_rx(c1); model_cmd(c1); end
        wait_done(timed_out);
        chk("pops", act_pops, exp_pops);
        chk("pipe_resets", act_resets, exp_resets);
        chk("pipe_enables", act_en, exp_en);
        chk("idle_dump_index", {30'd0, dump_index}, 32'd0);
    endtask

    // Monitor: count strobes and pop/compare TX bytes
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clock);
            if (!reset) begin
                act_pops   += int'(rx_read_next);
                act_resets += int'(pipe_reset);
                act_en     += int'(pipe_enable);
                if (tx_write_flag) begin
                    act_writes++;
                    checks++;
                    if (tx_full) begin
                        failures++;
                        $display("FAIL tx_write_while_full actual=1 expected=0");
                    end else if (tx_exp.size() == 0) begin
                        failures++;
                        $display("FAIL tx_unexpected actual=%0h expected=none", tx_data);
                    end else begin
                        e = tx_exp.pop_front();
                        if (tx_data !== e) begin
                            failures++;
                            $display("FAIL tx_byte actual=%0h expected=%0h", tx_data, e);
                        end
                    end
                end
            end
        end
    end

    // TX backpressure: random, or a 5-cycle burst after the 3rd byte of a dump
    initial begin
        forever begin
            @(posedge clock); #1;
            if (burst_arm && act_writes == burst_base + 3) begin
                tx_full = 1'b1;
                repeat (5) begin @(posedge clock); #1; end
                tx_full = 1'b0;
                burst_arm = 1'b0;
            end else begin
                tx_full = full_rand_en && ($urandom_range(0, 99) < 25);
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1);
    end

    initial begin
        logic [7:0] codes[5];
        logic [7:0] c0, c1;
        logic       to;
        int         base;
        codes = '{8'h63, 8'h73, 8'h72, 8'h64, 8'h00};
        to = 1'b0;
        dmem[0] = 32'h11223344; dmem[1] = 32'h55667788;
        dmem[2] = 32'h99AABBCC; dmem[3] = 32'hDDEEF001;

        repeat (3) @(posedge clock);
        #1;
        chk("rst_rx_read_next", {31'd0, rx_read_next}, 32'd0);
        chk("rst_tx_write_flag", {31'd0, tx_write_flag}, 32'd0);
        chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
        chk("rst_pipe_enable", {31'd0, pipe_enable}, 32'd0);
        chk("rst_pipe_reset", {31'd0, pipe_reset}, 32'd0);
        chk("rst_dump_index", {30'd0, dump_index}, 32'd0);
        reset = 1'b0;
        repeat (6) begin @(posedge clock); #1; end
        chk("idle_no_pops", act_pops, 0);
        chk("idle_no_writes", act_writes, 0);

        prog_len = 8'd10;
        run_batch(8'h72, 8'h00, 1, to);
        chk("prst_no_tx", act_writes, 0);
        if (!to) run_batch(8'h73, 8'h00, 1, to);
        if (!to) run_batch(8'h72, 8'h63, 2, to);
        if (!to) begin
            burst_arm = 1'b1; burst_base = act_writes;
            run_batch(8'h64, 8'h00, 1, to);
        end
        if (!to) run_batch(8'h41, 8'h00, 1, to);

        for (int i = 0; i < 40 && !to; i++) begin
            for (int w = 0; w < NW; w++) dmem[w] = $urandom;
            prog_len = 8'($urandom_range(0, 12));
            full_rand_en = ($urandom_range(0, 1) == 1);
            c0 = codes[$urandom_range(0, 4)];
            if (c0 == 8'h00) c0 = 8'($urandom_range(0, 255));
            c1 = codes[$urandom_range(0, 4)];
            if (c1 == 8'h00) c1 = 8'($urandom_range(0, 255));
            run_batch(c0, c1, int'($urandom_range(1, 2)), to);
        end

        full_rand_en = 1'b0;
        if (!to) begin
            base = act_writes;
            push_rx(8'h64); model_cmd(8'h64);
            for (int t = 0; t < 200 && act_writes < base + 3; t++) begin
                @(posedge clock); #1;
            end
            chk("mid_send_progress", 32'(act_writes >= base + 3), 32'd1);
            reset = 1'b1;
            #1;
            chk("midrst_tx_write_flag", {31'd0, tx_write_flag}, 32'd0);
            chk("midrst_tx_data", {24'd0, tx_data}, 32'd0);
            chk("midrst_rx_read_next", {31'd0, rx_read_next}, 32'd0);
            chk("midrst_pipe_enable", {31'd0, pipe_enable}, 32'd0);
            chk("midrst_pipe_reset", {31'd0, pipe_reset}, 32'd0);
            chk("midrst_dump_index", {30'd0, dump_index}, 32'd0);
            tx_exp.delete();
            base = act_writes;
            repeat (3) @(posedge clock);
            #1;
            reset = 1'b0;
            repeat (40) begin @(posedge clock); #1; end
            chk("writes_after_reset", act_writes, base);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
